// File: rtl/header_rr_arbiter.sv
// Multi-queue header arbiter: one FIFO per input channel feeding a single registered output
// stage, granted either work-conserving round-robin or fixed lowest-index priority.
module header_rr_arbiter #(
  parameter int unsigned C_TDATA_WIDTH   = 256,
  parameter int unsigned C_TUSER_WIDTH   = 128,
  parameter int unsigned NUM_QUEUES      = 5,
  parameter int unsigned FIFO_DEPTH_BITS = 3,
  parameter int unsigned ARB_MODE        = 0
) (
  input  logic                                  axi_aclk,
  input  logic                                  axi_resetn,
  input  logic [NUM_QUEUES*C_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_QUEUES*C_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                 s_axis_tvalid,
  output logic [NUM_QUEUES-1:0]                 s_axis_tready,
  output logic [C_TDATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_TUSER_WIDTH-1:0]              m_axis_tuser,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [$clog2(NUM_QUEUES)-1:0]         m_axis_tsrc,
  output logic [NUM_QUEUES-1:0]                 queue_empty
);

  localparam int unsigned SrcW  = $clog2(NUM_QUEUES);
  localparam int unsigned Depth = 2 ** FIFO_DEPTH_BITS;
  localparam int unsigned PtrW  = FIFO_DEPTH_BITS + 1;

  logic [C_TDATA_WIDTH-1:0] data_mem [NUM_QUEUES][Depth];
  logic [C_TUSER_WIDTH-1:0] user_mem [NUM_QUEUES][Depth];
  logic [PtrW-1:0]          wr_ptr_q [NUM_QUEUES];
  logic [PtrW-1:0]          rd_ptr_q [NUM_QUEUES];

  logic [NUM_QUEUES-1:0] full, empty, push, pop;
  logic [SrcW-1:0]       last_grant_q, rr_idx, fp_idx, grant_idx;
  logic                  rr_found, load;
  int                    cand;

  logic [C_TDATA_WIDTH-1:0] m_data_q;
  logic [C_TUSER_WIDTH-1:0] m_user_q;
  logic [SrcW-1:0]          m_src_q;
  logic                     m_valid_q;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < int'(NUM_QUEUES); i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][PtrW-1] != rd_ptr_q[i][PtrW-1]) &&
                 (wr_ptr_q[i][FIFO_DEPTH_BITS-1:0] == rd_ptr_q[i][FIFO_DEPTH_BITS-1:0]);
    end
  end

  assign push = s_axis_tvalid & ~full;

  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    fp_idx   = '0;
    cand     = 0;
    // Search upward from last_grant+1 with wrap, so the previous winner is considered last.
    for (int off = 1; off <= int'(NUM_QUEUES); off++) begin
      cand = int'(last_grant_q) + off;
      if (cand >= int'(NUM_QUEUES)) cand = cand - int'(NUM_QUEUES);
      if (!rr_found && !empty[cand]) begin
        rr_idx   = SrcW'(cand);
        rr_found = 1'b1;
      end
    end
    for (int i = int'(NUM_QUEUES) - 1; i >= 0; i--) begin
      if (!empty[i]) fp_idx = SrcW'(i);
    end
  end

  assign grant_idx = (ARB_MODE == 1) ? fp_idx : rr_idx;
  assign load      = (!m_valid_q || m_axis_tready) && !(&empty);
  assign pop       = load ? (NUM_QUEUES'(1) << grant_idx) : '0;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      for (int i = 0; i < int'(NUM_QUEUES); i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_QUEUES); i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
      end
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge axi_aclk) begin
    for (int i = 0; i < int'(NUM_QUEUES); i++) begin
      if (push[i]) begin
        data_mem[i][wr_ptr_q[i][FIFO_DEPTH_BITS-1:0]] <=
          s_axis_tdata[i*int'(C_TDATA_WIDTH) +: C_TDATA_WIDTH];
        user_mem[i][wr_ptr_q[i][FIFO_DEPTH_BITS-1:0]] <=
          s_axis_tuser[i*int'(C_TUSER_WIDTH) +: C_TUSER_WIDTH];
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_user_q     <= '0;
      m_src_q      <= '0;
      last_grant_q <= SrcW'(NUM_QUEUES - 1);
    end else if (load) begin
      m_valid_q    <= 1'b1;
      m_data_q     <= data_mem[grant_idx][rd_ptr_q[grant_idx][FIFO_DEPTH_BITS-1:0]];
      m_user_q     <= user_mem[grant_idx][rd_ptr_q[grant_idx][FIFO_DEPTH_BITS-1:0]];
      m_src_q      <= grant_idx;
      last_grant_q <= grant_idx;
    end else if (m_axis_tready) begin
      m_valid_q    <= 1'b0;
    end
  end

  assign s_axis_tready = ~full;
  assign queue_empty   = empty;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tsrc   = m_src_q;

endmodule
